// File: rtl/piso_pkg.sv
// Shared types and constants for the piso8bit_tx serializer.
// Optional feature macro: PISO_PARITY_EN adds an even-parity bit after the data bits.
package piso_pkg;

    // Default parallel word width / number of data bits per frame.
    localparam int unsigned DATA_W_DEF = 8;

    // Bit counter must hold DATA_W itself, so it needs clog2(DATA_W+1) bits.
    function automatic int unsigned piso_cnt_w(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

    localparam int unsigned CNT_W_DEF = $clog2(DATA_W_DEF + 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StPar   = 2'd2,
        StDone  = 2'd3
    } piso_state_e;
`else
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd3
    } piso_state_e;
`endif

endpackage

// File: rtl/piso_shreg.sv
// Data path of the serializer: the parallel-load shift register and its bit counter.
// Load wins over shift; reset wins over both.
module piso_shreg
    import piso_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = piso_cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_shift,
    output logic              o_msb,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_count;

    // Capture a new word and clear the count, or shift left with zero fill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_shreg <= i_din;
            r_count <= '0;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_msb   = r_shreg[DATA_W-1];
    assign o_count = r_count;

endmodule

// File: rtl/piso8bit_tx.sv
// Parallel-in serial-out transmitter: accepts a word in IDLE, shifts it out MSB first
// under shift_en control, then pulses done for one cycle.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit (state PAR).
module piso8bit_tx
    import piso_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              shift_en,
    output logic              sout,
    output logic              sout_valid,
    output logic              done
);

    localparam int unsigned CntW = piso_cnt_w(DATA_W);
    // Count value seen while the last data bit is on sout.
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    piso_state_e     r_state;
    piso_state_e     w_state_nxt;
    logic            w_load;
    logic            w_shift;
    logic            w_msb;
    logic [CntW-1:0] w_count;

    piso_shreg #(
        .DATA_W (DATA_W),
        .CNT_W  (CntW)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_din   (din),
        .i_shift (w_shift),
        .o_msb   (w_msb),
        .o_count (w_count)
    );

`ifdef PISO_PARITY_EN
    logic r_parity;

    // Parity of the accepted word; din is not looked at again during the frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^din;
        end
    end
`endif

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, data path controls and Moore-style outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        load_ready  = 1'b0;
        sout        = 1'b0;
        sout_valid  = 1'b0;
        done        = 1'b0;
        case (r_state)
            StIdle: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = StShift;
                end
            end
            StShift: begin
                sout       = w_msb;
                sout_valid = 1'b1;
                if (shift_en) begin
                    w_shift = 1'b1;
                    if (w_count == LastCnt) begin
`ifdef PISO_PARITY_EN
                        w_state_nxt = StPar;
`else
                        w_state_nxt = StDone;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            StPar: begin
                sout       = r_parity;
                sout_valid = 1'b1;
                if (shift_en) begin
                    w_state_nxt = StDone;
                end
            end
`endif
            StDone: begin
                done        = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_piso8bit_tx.sv
// Self-checking bench for piso8bit_tx: a directed vector table, hand-written frame
// sequences and randomized cycles, all checked against a queue-based frame model.
// Honours PISO_PARITY_EN the same way the design does.
module tb_piso8bit_tx;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       load_valid;
    logic       load_ready;
    logic       shift_en;
    logic       sout;
    logic       sout_valid;
    logic       done;

    int n_vec;
    int n_err;

    piso8bit_tx #(
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A frame is a queue of bits still to be sent; an empty queue while busy is the
    // done cycle.  Outputs packed as {load_ready, sout, sout_valid, done}.
    bit m_busy;
    bit m_q[$];

    function automatic logic [3:0] m_out();
        if (!m_busy) return 4'b1000;
        if (m_q.size() > 0) return {1'b0, m_q[0], 1'b1, 1'b0};
        return 4'b0001;
    endfunction

    function automatic void m_edge(input logic rst, input logic lv, input logic [7:0] d,
                                   input logic se);
        if (!rst) begin
            m_busy = 1'b0;
            m_q.delete();
        end else if (!m_busy) begin
            if (lv) begin
                m_busy = 1'b1;
                m_q.delete();
                for (int i = 7; i >= 0; i--) m_q.push_back(d[i]);
`ifdef PISO_PARITY_EN
                m_q.push_back(^d);
`endif
            end
        end else if (m_q.size() > 0) begin
            if (se) void'(m_q.pop_front());
        end else begin
            m_busy = 1'b0;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, check against the
    // model, then let the rising edge advance both DUT and model.
    task automatic step(input logic rst, input logic lv, input logic [7:0] d, input logic se,
                        output logic [3:0] obs);
        logic [3:0] exp;
        reset      = rst;
        load_valid = lv;
        din        = d;
        shift_en   = se;
        @(negedge clk);
        obs = {load_ready, sout, sout_valid, done};
        exp = m_out();
        chk("model", {28'd0, obs}, {28'd0, exp});
        @(posedge clk);
        m_edge(rst, lv, d, se);
        #1;
    endtask

    // Send one word and observe the whole frame.  shift_en is dropped for stall_len
    // cycles once stall_at bits have been accepted; lv_mid/d_mid are driven mid-frame.
    task automatic frame(input logic [7:0] w, input logic lv_mid, input logic [7:0] d_mid,
                         input int stall_at, input int stall_len,
                         output logic [7:0] got, output logic par,
                         output int done_cyc, output int nvalid);
        logic [3:0] obs;
        int nacc;
        int stalls;
        logic se;
        got      = 8'h00;
        par      = 1'b0;
        done_cyc = 0;
        nvalid   = 0;
        nacc     = 0;
        stalls   = 0;
        step(1'b1, 1'b1, w, 1'b1, obs);
        for (int k = 1; k <= 40; k++) begin
            se = 1'b1;
            if (nacc == stall_at && stalls < stall_len) begin
                se = 1'b0;
                stalls++;
            end
            step(1'b1, lv_mid, d_mid, se, obs);
            if (obs[1]) begin
                nvalid++;
                if (se) begin
                    if (nacc < 8) got = {got[6:0], obs[2]};
                    else          par = obs[2];
                    nacc++;
                end
            end
            if (obs[0]) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] d;
        logic       se;
        logic [3:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic lv, input logic [7:0] d,
                                input logic se, input logic [3:0] exp);
        vec_t v;
        v.rst = rst;
        v.lv  = lv;
        v.d   = d;
        v.se  = se;
        v.exp = exp;
        return v;
    endfunction

`ifdef PISO_PARITY_EN
    localparam int ParExtra = 1;
`else
    localparam int ParExtra = 0;
`endif

    vec_t tbl[$];

    initial begin
        logic [3:0] obs;
        logic [7:0] word;
        logic [7:0] got;
        logic       par;
        int         dcyc;
        int         nval;

        n_vec = 0;
        n_err = 0;

        // Reset held low three cycles, then an A5 frame with shift_en high.
        word = 8'hA5;
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 4'b1000));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 4'b1000));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 4'b1000));
        tbl.push_back(mk(1'b1, 1'b1, word,  1'b1, 4'b1000));
        for (int i = 7; i >= 0; i--) begin
            tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, {1'b0, word[i], 1'b1, 1'b0}));
        end
`ifdef PISO_PARITY_EN
        tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, {1'b0, 1'b0, 1'b1, 1'b0}));
`endif
        tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 4'b0001));
        tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 4'b1000));

        reset      = 1'b0;
        load_valid = 1'b0;
        din        = 8'h00;
        shift_en   = 1'b0;
        m_busy     = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].lv, tbl[i].d, tbl[i].se, obs);
            chk($sformatf("tbl[%0d]", i), {28'd0, obs}, {28'd0, tbl[i].exp});
        end

        // F0 with a three-cycle stall while bit 2 is on sout.
        frame(8'hF0, 1'b0, 8'h00, 1, 3, got, par, dcyc, nval);
        chk("f0_bits", {24'd0, got}, 32'h0000_00F0);
        chk("f0_valid_cycles", nval, 11 + ParExtra);
        chk("f0_done_cycle", dcyc, 12 + ParExtra);

        // 3C while load_valid/FF is asserted throughout the frame.
        frame(8'h3C, 1'b1, 8'hFF, 0, 0, got, par, dcyc, nval);
        chk("3c_bits", {24'd0, got}, 32'h0000_003C);
        chk("3c_done_cycle", dcyc, 9 + ParExtra);
        step(1'b1, 1'b0, 8'h00, 1'b1, obs);
        chk("3c_ready_after", {28'd0, obs}, 32'h8);

        // Reset after bit 4 of A5 aborts the frame; 81 then goes out intact.
        step(1'b1, 1'b1, 8'hA5, 1'b1, obs);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1, obs);
        step(1'b0, 1'b0, 8'h00, 1'b1, obs);
        step(1'b1, 1'b0, 8'h00, 1'b1, obs);
        chk("abort_idle", {28'd0, obs}, 32'h8);
        frame(8'h81, 1'b0, 8'h00, 0, 0, got, par, dcyc, nval);
        chk("81_bits", {24'd0, got}, 32'h0000_0081);
        chk("81_done_cycle", dcyc, 9 + ParExtra);

`ifdef PISO_PARITY_EN
        frame(8'h07, 1'b0, 8'h00, 0, 0, got, par, dcyc, nval);
        chk("07_bits", {24'd0, got}, 32'h0000_0007);
        chk("07_parity", {31'd0, par}, 32'h1);
        chk("07_done_cycle", dcyc, 10);
        frame(8'h03, 1'b0, 8'h00, 0, 0, got, par, dcyc, nval);
        chk("03_parity", {31'd0, par}, 32'h0);
        chk("03_done_cycle", dcyc, 10);
`endif

        // Randomized cycles: occasional reset, sporadic loads, bursty shift_en.
        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(63) != 0, $urandom_range(3) == 0, 8'($urandom),
                 $urandom_range(9) < 7, obs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
